// File: rtl/wm8731_i2c_responder_pkg.sv
// Shared types and constants for the WM8731 2-wire control-port responder.
package wm8731_pkg;

  localparam logic [6:0] WM8731_ADDR = 7'h1A;

  localparam int unsigned WORD_ADDR_W = 7;
  localparam int unsigned WORD_DATA_W = 9;

  localparam logic [6:0] REG_LLINE  = 7'd0;
  localparam logic [6:0] REG_RLINE  = 7'd1;
  localparam logic [6:0] REG_LHP    = 7'd2;
  localparam logic [6:0] REG_RHP    = 7'd3;
  localparam logic [6:0] REG_APANA  = 7'd4;
  localparam logic [6:0] REG_APDIG  = 7'd5;
  localparam logic [6:0] REG_PWR    = 7'd6;
  localparam logic [6:0] REG_IFACE  = 7'd7;
  localparam logic [6:0] REG_SRATE  = 7'd8;
  localparam logic [6:0] REG_ACTIVE = 7'd9;
  localparam logic [6:0] REG_RESET  = 7'd15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK_DEV,
    ST_HI,
    ST_ACK_HI,
    ST_LO,
    ST_ACK_LO,
    ST_DONE,
    ST_IGNORE
  } resp_state_e;

endpackage

// File: rtl/wm8731_i2c_responder_i2c_line_filter.sv
// Two-flop synchronizer followed by a FILT_LEN-sample glitch filter.
// Output level changes 2+FILT_LEN clk cycles after the pin settles.
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FILT_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], pin};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q == '0) begin
      filt_d = sync_q[1];
      cnt_d  = CNT_LOAD;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Preload high so a reset never fabricates a bus edge on an idle line.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= CNT_LOAD;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;

endmodule

// File: rtl/wm8731_i2c_responder.sv
// WM8731 2-wire control-port responder: receives one 16-bit write word per transfer.
// Optional shadow register file enabled by WM8731_I2C_RESPONDER_REGFILE_EN.
//
// state      | meaning
// IDLE       | waiting for START
// DEV        | shifting the device address byte
// ACK_DEV    | ACK slot after a matching address
// HI         | shifting word[15:8]
// ACK_HI     | ACK slot after the high byte
// LO         | shifting word[7:0]
// ACK_LO     | ACK slot after the low byte; word published at its end
// DONE       | word captured, further bytes not ACKed
// IGNORE     | address mismatch, bus ignored until STOP/START
module wm8731_i2c_responder
  import wm8731_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = WM8731_ADDR,
  parameter int unsigned FILT_LEN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCLK,
  inout  wire        SDIN,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       busy,
  output logic       addr_nack
`ifdef WM8731_I2C_RESPONDER_REGFILE_EN
  ,
  output logic [143:0] shadow_flat
`endif
);

  logic scl_f, sda_f;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk  (clk),
    .reset(reset),
    .pin  (SCLK),
    .level(scl_f)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk  (clk),
    .reset(reset),
    .pin  (SDIN),
    .level(sda_f)
  );

  resp_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hi_q, hi_d;
  logic        sda_oe_q, sda_oe_d;
  logic        scl_prev_q, sda_prev_q;
  logic        wr_valid_q, wr_valid_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [8:0]  wr_data_q, wr_data_d;
  logic        nack_q, nack_d;

  logic scl_rise, scl_fall, bus_start, bus_stop, byte_done;
  logic [7:0] byte_in;

  assign scl_rise  = scl_f & ~scl_prev_q;
  assign scl_fall  = ~scl_f & scl_prev_q;
  assign bus_start = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign bus_stop  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  assign byte_in   = {shift_q[6:0], sda_f};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    nack_d     = 1'b0;

    unique case (state_q)
      ST_DEV, ST_HI, ST_LO: begin
        if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (byte_done) begin
          if (state_q == ST_DEV) begin
            if (byte_in == {DEV_ADDR, 1'b0}) begin
              state_d = ST_ACK_DEV;
            end else begin
              nack_d  = 1'b1;
              state_d = ST_IGNORE;
            end
          end else if (state_q == ST_HI) begin
            hi_d    = byte_in;
            state_d = ST_ACK_HI;
          end else begin
            state_d = ST_ACK_LO;
          end
        end
      end
      // First falling edge starts the ACK, the second one ends the slot.
      ST_ACK_DEV, ST_ACK_HI, ST_ACK_LO: begin
        if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            if (state_q == ST_ACK_DEV) begin
              state_d = ST_HI;
            end else if (state_q == ST_ACK_HI) begin
              state_d = ST_LO;
            end else begin
              state_d    = ST_DONE;
              wr_valid_d = 1'b1;
              wr_addr_d  = hi_q[7:1];
              wr_data_d  = {hi_q[0], shift_q};
            end
          end
        end
      end
      default: ;
    endcase

    if (bus_stop) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else if (bus_start) begin
      state_d   = ST_DEV;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      hi_q       <= 8'h00;
      sda_oe_q   <= 1'b0;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 7'h00;
      wr_data_q  <= 9'h000;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      sda_oe_q   <= sda_oe_d;
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      nack_q     <= nack_d;
    end
  end

  assign SDIN      = sda_oe_q ? 1'b0 : 1'bz;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign addr_nack = nack_q;

  always_comb begin
    busy = 1'b0;
    if (state_q inside {ST_ACK_DEV, ST_HI, ST_ACK_HI, ST_LO, ST_ACK_LO, ST_DONE}) begin
      busy = 1'b1;
    end
  end

`ifdef WM8731_I2C_RESPONDER_REGFILE_EN
  logic [8:0] shadow_q [16];
  logic [8:0] shadow_d [16];

  // Writes land one cycle after the wr_valid strobe, from the published word.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (wr_valid_q && (wr_addr_q[6:4] == 3'd0)) begin
      if (wr_addr_q == REG_RESET) begin
        for (int i = 0; i < 16; i++) begin
          shadow_d[i] = 9'h000;
        end
      end else begin
        shadow_d[wr_addr_q[3:0]] = wr_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (reset) begin
        shadow_q[i] <= 9'h000;
      end else begin
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  for (genvar n = 0; n < 16; n++) begin : g_flat
    assign shadow_flat[9*n +: 9] = shadow_q[n];
  end
`endif

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Directed bench for wm8731_i2c_responder: table of full write transfers plus
// hand sequences for aborted, restarted and reset-interrupted transfers.
`timescale 1ns/1ps
module tb_wm8731_i2c_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       tb_sda_low;
  wire        SDIN;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       addr_nack;
`ifdef WM8731_I2C_RESPONDER_REGFILE_EN
  logic [143:0] shadow_flat;
`endif

  wm8731_i2c_responder dut (
    .clk      (clk),
    .reset    (reset),
    .SCLK     (scl),
    .SDIN     (SDIN),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .addr_nack(addr_nack)
`ifdef WM8731_I2C_RESPONDER_REGFILE_EN
    ,
    .shadow_flat(shadow_flat)
`endif
  );

  assign SDIN = tb_sda_low ? 1'b0 : 1'bz;
  pullup (SDIN);

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int valid_cnt = 0;
  int nack_cnt = 0;
  int dut_low_cnt = 0;

  always @(negedge clk) begin
    if (wr_valid === 1'b1) valid_cnt++;
    if (addr_nack === 1'b1) nack_cnt++;
    if (SDIN === 1'b0 && !tb_sda_low) dut_low_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      #50 tb_sda_low = ~b[i];
      #50 scl = 1'b1;
      #100 scl = 1'b0;
    end
  endtask

  task automatic ack_slot(output logic acked);
    #50 tb_sda_low = 1'b0;
    #50 scl = 1'b1;
    #50 acked = (SDIN === 1'b0);
    #50 scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl) begin
      #50 tb_sda_low = 1'b0;
      #50 scl = 1'b1;
      #100;
    end
    tb_sda_low = 1'b1;
    #100 scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #50 tb_sda_low = 1'b1;
    #50 scl = 1'b1;
    #100 tb_sda_low = 1'b0;
    #200;
  endtask

  task automatic xfer(input logic [7:0] dev, input logic [15:0] w, output logic [2:0] acks);
    logic a2, a1, a0;
    i2c_start();
    send_bits(dev);     ack_slot(a2);
    send_bits(w[15:8]); ack_slot(a1);
    send_bits(w[7:0]);  ack_slot(a0);
    i2c_stop();
    acks = {a2, a1, a0};
  endtask

  typedef struct {
    logic [7:0]  dev;
    logic [15:0] word;
    logic [2:0]  exp_ack;
    int          exp_valid;
    int          exp_nack;
    logic [6:0]  exp_addr;
    logic [8:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [2:0] acks;
    logic       a;
    int v0, n0, l0;

    vecs[0] = '{8'h34, 16'h1201, 3'b111, 1, 0, 7'h09, 9'h001};
    vecs[1] = '{8'h36, 16'hABCD, 3'b000, 0, 1, 7'h09, 9'h001};
    vecs[2] = '{8'h34, 16'h0460, 3'b111, 1, 0, 7'h02, 9'h060};
    vecs[3] = '{8'h34, 16'h0C00, 3'b111, 1, 0, 7'h06, 9'h000};
    vecs[4] = '{8'h34, 16'h0812, 3'b111, 1, 0, 7'h04, 9'h012};
    vecs[5] = '{8'h35, 16'h0000, 3'b000, 0, 1, 7'h04, 9'h012};

    reset = 1'b1;
    scl = 1'b1;
    tb_sda_low = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_nack", addr_nack, 0);
    chk("rst_sdin_released", SDIN === 1'b0, 0);
    reset = 1'b0;
    repeat (10) @(posedge clk);

    for (int k = 0; k < 6; k++) begin
      v0 = valid_cnt; n0 = nack_cnt; l0 = dut_low_cnt;
      xfer(vecs[k].dev, vecs[k].word, acks);
      $display("[TB] vec %0d dev=%0h word=%0h", k, vecs[k].dev, vecs[k].word);
      chk("vec_ack_dev", acks[2], vecs[k].exp_ack[2]);
      chk("vec_ack_hi", acks[1], vecs[k].exp_ack[1]);
      chk("vec_ack_lo", acks[0], vecs[k].exp_ack[0]);
      chk("vec_valid_pulses", valid_cnt - v0, vecs[k].exp_valid);
      chk("vec_nack_pulses", nack_cnt - n0, vecs[k].exp_nack);
      chk("vec_wr_addr", wr_addr, vecs[k].exp_addr);
      chk("vec_wr_data", wr_data, vecs[k].exp_data);
      chk("vec_busy_after_stop", busy, 0);
      if (vecs[k].exp_nack != 0) chk("vec_nack_no_drive", dut_low_cnt - l0, 0);
    end

    // STOP after the first data byte: partial word discarded.
    v0 = valid_cnt;
    i2c_start();
    send_bits(8'h34); ack_slot(a);
    chk("part_ack_dev", a, 1);
    send_bits(8'h12); ack_slot(a);
    chk("part_ack_hi", a, 1);
    chk("part_busy_mid", busy, 1);
    i2c_stop();
    chk("part_no_valid", valid_cnt - v0, 0);
    chk("part_addr_hold", wr_addr, 7'h04);
    chk("part_data_hold", wr_data, 9'h012);
    chk("part_busy_idle", busy, 0);

    // Repeated START after ACK_HI, then full word and a 4th byte.
    v0 = valid_cnt;
    i2c_start();
    send_bits(8'h34); ack_slot(a);
    send_bits(8'h12); ack_slot(a);
    i2c_start();
    send_bits(8'h34); ack_slot(a);
    chk("rs_ack_dev", a, 1);
    send_bits(8'h0E); ack_slot(a);
    chk("rs_ack_hi", a, 1);
    send_bits(8'h23); ack_slot(a);
    chk("rs_ack_lo", a, 1);
    send_bits(8'hFF); ack_slot(a);
    chk("rs_byte4_nacked", a, 0);
    i2c_stop();
    chk("rs_valid_once", valid_cnt - v0, 1);
    chk("rs_wr_addr", wr_addr, 7'h07);
    chk("rs_wr_data", wr_data, 9'h023);

    // Reset while the responder holds the ACK low.
    v0 = valid_cnt;
    i2c_start();
    send_bits(8'h34);
    #50 tb_sda_low = 1'b0;
    #50;
    chk("rst_mid_ack_driven", SDIN === 1'b0, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_sdin_released", SDIN === 1'b0, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", busy, 0);
    #50 scl = 1'b1;
    #200;
    xfer(8'h34, 16'h0812, acks);
    chk("post_rst_acks", acks, 3'b111);
    chk("post_rst_addr", wr_addr, 7'h04);
    chk("post_rst_data", wr_data, 9'h012);
`ifdef WM8731_I2C_RESPONDER_REGFILE_EN
    chk("shadow_reg4", shadow_flat[36 +: 9], 9'h012);
`endif
    xfer(8'h34, 16'h1E00, acks);
    chk("reset_word_acks", acks, 3'b111);
    chk("reset_word_addr", wr_addr, 7'h0F);
    chk("reset_word_data", wr_data, 9'h000);
    chk("post_rst_valid_cnt", valid_cnt - v0, 2);
`ifdef WM8731_I2C_RESPONDER_REGFILE_EN
    chk("shadow_cleared", shadow_flat == 144'd0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wm8731_i2c_responder.md
Name: wm8731_i2c_responder

Overview:
- I2C target (responder) modelling the WM8731 2-wire control port: the far end of the codec configuration initiator.
- Detects START/STOP on SCLK/SDIN and matches the device address (write only). Receives one 16-bit control word: {reg_addr[6:0], reg_data[8:0]}.
- ACKs each byte by pulling SDIN low, then presents the decoded word with a one-cycle valid strobe.
- Used as a bench/loopback model and as a capture monitor on the configuration bus.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit target address; the expected address byte is 8'h34.
- FILT_LEN, 2, number of consecutive equal samples needed before a filtered SCLK/SDIN level changes (glitch filter depth, min 1).

Ports:
- clk  input  1  system clock; must be at least 8x the SCLK rate.
- reset  input  1  synchronous, active-high reset.
- SCLK  input  1  I2C clock from the initiator (asynchronous to clk).
- SDIN  inout  1  I2C data; this block drives only 1'b0 (ACK), otherwise 1'bz.
- wr_valid  output  1  one-cycle pulse: a complete word was received and ACKed.
- wr_addr  output  7  register address, bits [15:9] of the word.
- wr_data  output  9  register data, bits [8:0] of the word.
- busy  output  1  high from a matched address until STOP or IDLE.
- addr_nack  output  1  one-cycle pulse when the address byte does not match or R/W=1.

Behaviour:
- Input conditioning:
  - SCLK and the SDIN input each pass through a 2-flop synchronizer, then a FILT_LEN glitch filter.
  - Filtered-edge latency from a pin change is 2+FILT_LEN clk cycles.
- Bus events, decoded from filtered levels:
  - START = SDIN falls while SCLK high.
  - STOP = SDIN rises while SCLK high.
  - Data bits are sampled on the filtered SCLK rising edge, MSB first.
- State machine:
  - IDLE: wait for START.
  - DEV: shift 8 bits. Byte == {DEV_ADDR,0} -> ACK_DEV. Otherwise pulse addr_nack and go to IGNORE.
  - ACK_DEV: drive SDIN low from the SCLK falling edge after bit 8 until the next SCLK falling edge, then go to HI.
  - HI: shift 8 bits into word[15:8], then ACK_HI (same ACK timing), then LO.
  - LO: shift 8 bits into word[7:0], then ACK_LO.
  - ACK_LO: at the SCLK falling edge that ends the ACK slot, pulse wr_valid for 1 clk, update wr_addr/wr_data, go to DONE.
  - DONE: any further bytes are not ACKed (SDIN stays z); wait for STOP/START.
  - IGNORE: SDIN stays z; wait for STOP/START.
- STOP in any state -> IDLE and busy=0. A partial word is discarded (no wr_valid).
- Repeated START in any state -> DEV with the bit counter cleared.
- wr_addr/wr_data hold their value until the next complete word.
- Reset values:
  - State IDLE; SDIN released (z).
  - wr_valid=0, wr_addr=0, wr_data=0, busy=0, addr_nack=0.
  - Filters preload to 1 (bus idle high).
- Reset asserted mid-transfer: SDIN is released in the same cycle and the block ignores the bus until the next START.
- The SDIN drive enable changes only on a filtered SCLK falling edge, so SDIN never changes while SCLK is high.

Optional Feature:
- Macro: WM8731_I2C_RESPONDER_REGFILE_EN.
- When defined:
  - Adds an internal 9-bit x 16 shadow register file written on wr_valid when wr_addr < 16.
  - Adds output port `shadow_flat [143:0]`, with register n at bits [9n+8:9n].
  - A write to address 7'h0F (reset register) clears all entries to 0 in the same cycle instead of storing its data.
  - Shadow registers reset to 0.
- When undefined: no storage and no shadow_flat port.

Decomposition:
- Shared package `wm8731_pkg`:
  - The state enum.
  - WM8731_ADDR = 7'h1A.
  - Register index constants (LLINE=0 ... ACTIVE=9, RESET=15).
  - Word field widths 7/9.
- One sub-module `i2c_line_filter`: synchronizer plus FILT_LEN filter, instantiated for SCLK and for SDIN.

Test Plan:
- Write 16'h1201 to address 8'h34 with STOP -> ACK low in all 3 ACK slots; wr_valid pulses once; wr_addr=7'h09, wr_data=9'h001; busy drops after STOP.
- Address byte 8'h36 then 2 bytes -> addr_nack pulses; SDIN never driven low; no wr_valid.
- Sequence 16'h0460, 16'h0C00, 16'h0812, each with its own START/STOP -> three wr_valid pulses with (02,060), (06,000), (04,012).
- STOP after the first data byte 8'h12 -> no wr_valid; wr_addr/wr_data keep their previous values; state IDLE.
- Repeated START after ACK_HI, then full word 16'h0E23 -> single wr_valid with (07,023); a 4th byte is NACKed.
- Reset asserted while driving an ACK -> SDIN z on the next clk; the following valid transaction is received normally. With REGFILE_EN, a write of 16'h1E00 clears shadow_flat to 0.
